load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised load/store unit that sits between the execute/memory stage and the data-memory port. It accepts one RV32I/RV64I load or store request at a time and drives a read/write handshake to memory. It generates byte enables and lane-shifted write data, then returns sign- or zero-extended load data. Boundary-crossing accesses either split into two memory beats or are rejected, depending on build configuration.

## Interface
- DATA_W, 32: memory/register data width; legal values 32 or 64. BYTES = DATA_W/8.
- ADDR_W, 32: address width.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned-rejected or illegal funct3; valid with resp_valid
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_address  out  ADDR_W  BYTES-aligned address
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_byte_enable  out  BYTES  active byte lanes
- mem_rdata  in  DATA_W  read data, valid with mem_resp
- mem_resp  in  1  one-cycle completion from memory

## Operation
- States: IDLE, ACCESS0, ACCESS1, DONE.
- IDLE: req_ready=1. On req_valid, capture the request and compute off = addr mod BYTES and size from funct3.
  - Illegal funct3 (store with an unsigned code, or LD/SD/LWU when DATA_W=32) goes to DONE with resp_err=1.
  - Legal requests go to ACCESS0.
- Crossing: off + size > BYTES. A non-crossing misaligned access (e.g. LH at offset 1, DATA_W=32) is serviced natively in one beat.
- ACCESS0: mem_read or mem_write held high.
  - mem_address = addr with low log2(BYTES) bits cleared.
  - mem_byte_enable = ((1<<size)-1) << off, truncated to BYTES.
  - mem_wdata = req_wdata << 8*off.
  - On mem_resp, go to ACCESS1 if crossing, else DONE.
- ACCESS1:
  - mem_address = aligned + BYTES, wrapping modulo 2^ADDR_W.
  - byte enables cover the remaining low lanes.
  - mem_wdata = req_wdata >> 8*(BYTES-off).
  - On mem_resp, go to DONE.
- Load assembly:
  - Beat0 contributes mem_rdata >> 8*off.
  - Beat1 contributes mem_rdata << 8*(BYTES-off), merged above it.
  - The result is truncated to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU).
  - Beat-0 data is held in an internal register.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in DONE.
- mem_resp while not in ACCESS0/ACCESS1 is ignored.

## Timing
- All outputs are registered or decoded from state only; none is combinational from req_* or mem_*.
- Reset (asynchronous), effective immediately and held while rst is high:
  - state=IDLE; req_ready=0 while rst is high, 1 afterwards.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0.
- Reset mid-transaction drops it: no resp_valid; a late mem_resp is ignored.
- Latency, with accept at edge 0:
  - One-beat access, mem_resp in the first ACCESS0 cycle: resp_valid in cycle 2, req_ready in cycle 3.
  - Two-beat access: resp_valid in cycle 3 minimum.
  - Error: resp_valid in cycle 1, no memory activity.
- Memory wait states extend ACCESS0/ACCESS1 indefinitely. Address, data and enables stay stable until mem_resp.
- mem_read and mem_write are never high together. Both drop in the cycle after mem_resp.

## Configuration
- LSU_MISALIGNED_SPLIT_EN defined: crossing accesses use ACCESS1 as above.
- LSU_MISALIGNED_SPLIT_EN undefined:
  - ACCESS1 is not built.
  - A crossing request goes IDLE→DONE with resp_err=1 and resp_rdata=0.
  - No mem_read or mem_write is issued.

## Test plan
- LW 0x100, DATA_W=32; memory returns 0xDEADBEEF with zero wait -> mem_address 0x100, byte_en 0xF, resp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
- LB 0x103, mem_rdata 0x80FF0000 -> mem_address 0x100, rdata 0xFFFFFF80; the same access as LBU -> 0x00000080.
- SH 0x201, wdata 0x0000ABCD -> mem_write, mem_address 0x200, byte_en 0b0110, mem_wdata 0x00ABCD00.
- Split on, LW 0x102:
  - Beat0 at 0x100 returns 0xBBAA0000; beat1 at 0x104 returns 0x0000DDCC.
  - Required: rdata 0xDDCCBBAA, resp_valid 3 cycles after accept.
  - Split off, same request: no mem_read, resp_err=1, resp_valid 1 cycle after accept.
- Split on, SW 0xFFFFFFFE, wdata 0x11223344:
  - Beat0 at 0xFFFFFFFC: byte_en 0b1100, wdata 0x33440000.
  - Beat1 at 0x00000000: byte_en 0b0011, wdata 0x00001122.
- Assert rst while ACCESS0 with 3 wait states -> mem_read drops the same cycle and no resp_valid appears. After release, an LD (DATA_W=64) to 0x8 completes normally; an LD with DATA_W=32 returns resp_err=1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory handshake of the
// load/store unit. The slave modport is the unit's view and the master modport
// is the surrounding pipeline and memory's view.
interface load_store_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_byte_enable;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RV32I/RV64I load/store unit between the memory
// stage and the data-memory port. Generates byte enables and lane-shifted store
// data, and returns sign/zero-extended load data.
// Build option LSU_MISALIGNED_SPLIT_EN: defined -> accesses crossing a BYTES
// boundary are split into two memory beats; undefined -> they are rejected with
// resp_err and never reach memory.
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam int SPAN  = 2;
`else
  localparam int SPAN  = 1;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS0, ACCESS1, DONE} state_t;
  state_t state, state_nxt;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [DATA_W-1:0] beat0_q;
`endif

  // access crosses into the next BYTES-aligned word
  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [1:0] sz);
    return (int'(off) + (1 << sz)) > BYTES;
  endfunction

  logic req_illegal, req_reject;

  // decode of the incoming request: illegal codes, and crossings when not splitting
  always_comb begin
    req_illegal = (bus.req_we && bus.req_funct3[2]) || (bus.req_funct3 == 3'b111) ||
                  ((DATA_W == 32) && (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110));
`ifdef LSU_MISALIGNED_SPLIT_EN
    req_reject  = req_illegal;
`else
    req_reject  = req_illegal || crosses(bus.req_addr[OFF_W-1:0], bus.req_funct3[1:0]);
`endif
  end

  int                     off_i, size_i;
  logic [ADDR_W-1:0]      aligned;
  logic [SPAN*BYTES-1:0]  be_wide;
  logic [SPAN*DATA_W-1:0] wd_wide, rd_wide;
  logic [DATA_W-1:0]      rd_lo, rd_ext;
  logic                   sbit;

  // lane datapath: span-wide enables/store data, load merge, shift and extend
  always_comb begin
    off_i   = int'(addr_q[OFF_W-1:0]);
    size_i  = 1 << f3_q[1:0];
    aligned = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    for (int i = 0; i < SPAN*BYTES; i++)
      be_wide[i] = (i >= off_i) && (i < off_i + size_i);
    wd_wide = (SPAN*DATA_W)'({{DATA_W{1'b0}}, wdata_q} << (8*off_i));
`ifdef LSU_MISALIGNED_SPLIT_EN
    rd_wide = (state == ACCESS1) ? {bus.mem_rdata, beat0_q} : {{DATA_W{1'b0}}, bus.mem_rdata};
`else
    rd_wide = bus.mem_rdata;
`endif
    rd_lo = DATA_W'(rd_wide >> (8*off_i));
    sbit  = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i == 8*size_i - 1) sbit = rd_lo[i] & ~f3_q[2];
    for (int i = 0; i < DATA_W; i++)
      rd_ext[i] = (i < 8*size_i) ? rd_lo[i] : sbit;
  end

  // state register; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = req_reject ? DONE : ACCESS0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      ACCESS0: if (bus.mem_resp)
                 state_nxt = crosses(addr_q[OFF_W-1:0], f3_q[1:0]) ? ACCESS1 : DONE;
      ACCESS1: if (bus.mem_resp) state_nxt = DONE;
`else
      ACCESS0: if (bus.mem_resp) state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // request capture, beat-0 hold and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      beat0_q <= '0;
`endif
    end else begin
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_reject;
        rdata_q <= '0;
      end
      if ((state == ACCESS0 || state == ACCESS1) && state_nxt == DONE && !we_q)
        rdata_q <= rd_ext;
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (state == ACCESS0 && bus.mem_resp) beat0_q <= bus.mem_rdata;
`endif
    end
  end

  // outputs decoded from state and captured registers only
  always_comb begin
    bus.req_ready       = (state == IDLE) && !rst;
    bus.resp_valid      = (state == DONE);
    bus.resp_err        = (state == DONE) && err_q;
    bus.resp_rdata      = (state == DONE) ? rdata_q : '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    case (state)
      ACCESS0: begin
        bus.mem_read        = !we_q;
        bus.mem_write       = we_q;
        bus.mem_address     = aligned;
        bus.mem_byte_enable = be_wide[BYTES-1:0];
        bus.mem_wdata       = we_q ? wd_wide[DATA_W-1:0] : '0;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ACCESS1: begin
        bus.mem_read        = !we_q;
        bus.mem_write       = we_q;
        bus.mem_address     = aligned + ADDR_W'(BYTES);
        bus.mem_byte_enable = be_wide[2*BYTES-1:BYTES];
        bus.mem_wdata       = we_q ? wd_wide[2*DATA_W-1:DATA_W] : '0;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit. A 32-bit instance is
// driven through a memory responder with configurable wait states and a
// response scoreboard; a 64-bit instance is driven by hand for LD/LW/LWU.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  load_store_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut   (.clk(clk), .rst(rst), .bus(b32));
  load_store_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder (32-bit instance) ----------------
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } beat_t;
  beat_t       log_q[$];
  logic [31:0] mem [logic [31:0]];
  int          wait_n = 0;
  logic        inject = 1'b0;

  initial begin
    int    cnt;
    beat_t bt;
    cnt = 0;
    b32.mem_resp  = 1'b0;
    b32.mem_rdata = '0;
    forever begin
      @(negedge clk);
      b32.mem_resp = 1'b0;
      if (rst) cnt = 0;
      else if (b32.mem_read || b32.mem_write) begin
        chk("rw_exclusive", b32.mem_read && b32.mem_write, 0);
        if (cnt >= wait_n) begin
          cnt = 0;
          b32.mem_resp  = 1'b1;
          b32.mem_rdata = mem.exists(b32.mem_address) ? mem[b32.mem_address] : 32'h0;
          bt.we = b32.mem_write; bt.addr = b32.mem_address;
          bt.be = b32.mem_byte_enable; bt.wdata = b32.mem_wdata;
          log_q.push_back(bt);
        end else cnt++;
      end else begin
        cnt = 0;
        if (inject) b32.mem_resp = 1'b1;
      end
    end
  end

  // ---------------- response scoreboard ----------------
  typedef struct { logic [31:0] rdata; logic err; string tag; } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (b32.resp_valid === 1'b1) begin
      chk("resp_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({e.tag, "_rdata"}, b32.resp_rdata, e.rdata);
        chk({e.tag, "_err"}, b32.resp_err, e.err);
      end
    end
  end

  // one request on the 32-bit unit; latency counted in cycles after the accept edge
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int elat);
    exp_t e;
    int   lat;
    log_q.delete();
    @(negedge clk);
    chk({tag, "_ready"}, b32.req_ready, 1);
    e.rdata = er; e.err = ee; e.tag = tag;
    sb_q.push_back(e);
    b32.req_valid = 1'b1; b32.req_we = we; b32.req_funct3 = f3;
    b32.req_addr = addr; b32.req_wdata = wd;
    @(posedge clk);
    #1;
    b32.req_valid = 1'b0; b32.req_addr = ~addr; b32.req_wdata = ~wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (b32.resp_valid !== 1'b1 && lat < 40);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_ready_in_done"}, b32.req_ready, 0);
    @(negedge clk);
    chk({tag, "_resp_one_cycle"}, b32.resp_valid, 0);
    chk({tag, "_ready_after"}, b32.req_ready, 1);
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic we,
                          input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    beat_t bt;
    bt = (idx < log_q.size()) ? log_q[idx] : '{we: 1'bx, addr: 'x, be: 'x, wdata: 'x};
    chk({tag, "_we"}, bt.we, we);
    chk({tag, "_addr"}, bt.addr, a);
    chk({tag, "_be"}, bt.be, be);
    if (we) chk({tag, "_wdata"}, bt.wdata, wd);
  endtask

  // one load on the 64-bit unit with a zero-wait hand-driven memory reply
  task automatic issue64(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] rd, input logic [31:0] ea,
                         input logic [7:0] ebe, input logic [63:0] er);
    @(negedge clk);
    b64.req_valid = 1'b1; b64.req_we = 1'b0; b64.req_funct3 = f3; b64.req_addr = addr;
    @(posedge clk);
    #1 b64.req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_read"}, b64.mem_read, 1);
    chk({tag, "_addr"}, b64.mem_address, ea);
    chk({tag, "_be"}, b64.mem_byte_enable, ebe);
    b64.mem_resp = 1'b1; b64.mem_rdata = rd;
    @(negedge clk);
    b64.mem_resp = 1'b0;
    chk({tag, "_valid"}, b64.resp_valid, 1);
    chk({tag, "_rdata"}, b64.resp_rdata, er);
    chk({tag, "_err"}, b64.resp_err, 0);
  endtask

  initial begin
    b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_funct3 = '0;
    b32.req_addr = '0; b32.req_wdata = '0;
    b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_funct3 = '0;
    b64.req_addr = '0; b64.req_wdata = '0; b64.mem_resp = 1'b0; b64.mem_rdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", b32.req_ready, 0);
    chk("rst_resp_valid", b32.resp_valid, 0);
    chk("rst_resp_err", b32.resp_err, 0);
    chk("rst_resp_rdata", b32.resp_rdata, 0);
    chk("rst_mem_rw", {b32.mem_read, b32.mem_write}, 0);
    chk("rst_mem_addr", b32.mem_address, 0);
    chk("rst_mem_wdata", b32.mem_wdata, 0);
    chk("rst_mem_be", b32.mem_byte_enable, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // aligned and natively-misaligned single-beat accesses
    mem[32'h100] = 32'hDEADBEEF;
    issue("lw", 1'b0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1'b0, 2);
    chk("lw_nbeats", log_q.size(), 1);
    chk_beat("lw_b0", 0, 1'b0, 32'h100, 4'hF, 0);

    mem[32'h100] = 32'h80FF0000;
    issue("lb", 1'b0, 3'b000, 32'h103, 0, 32'hFFFFFF80, 1'b0, 2);
    chk_beat("lb_b0", 0, 1'b0, 32'h100, 4'h8, 0);
    issue("lbu", 1'b0, 3'b100, 32'h103, 0, 32'h00000080, 1'b0, 2);
    issue("lh_off1", 1'b0, 3'b001, 32'h101, 0, 32'hFFFFFF00, 1'b0, 2);
    chk_beat("lh_off1_b0", 0, 1'b0, 32'h100, 4'b0110, 0);

    wait_n = 2;
    issue("sh", 1'b1, 3'b001, 32'h201, 32'h0000ABCD, 0, 1'b0, 4);
    chk("sh_nbeats", log_q.size(), 1);
    chk_beat("sh_b0", 0, 1'b1, 32'h200, 4'b0110, 32'h00ABCD00);
    wait_n = 0;

    // boundary-crossing accesses
    mem[32'h100] = 32'hBBAA0000;
    mem[32'h104] = 32'h0000DDCC;
`ifdef LSU_MISALIGNED_SPLIT_EN
    issue("lw_cross", 1'b0, 3'b010, 32'h102, 0, 32'hDDCCBBAA, 1'b0, 3);
    chk("lw_cross_nbeats", log_q.size(), 2);
    chk_beat("lw_cross_b0", 0, 1'b0, 32'h100, 4'b1100, 0);
    chk_beat("lw_cross_b1", 1, 1'b0, 32'h104, 4'b0011, 0);
    issue("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 0, 1'b0, 3);
    chk("sw_wrap_nbeats", log_q.size(), 2);
    chk_beat("sw_wrap_b0", 0, 1'b1, 32'hFFFFFFFC, 4'b1100, 32'h33440000);
    chk_beat("sw_wrap_b1", 1, 1'b1, 32'h00000000, 4'b0011, 32'h00001122);
`else
    issue("lw_cross", 1'b0, 3'b010, 32'h102, 0, 0, 1'b1, 1);
    chk("lw_cross_nbeats", log_q.size(), 0);
    issue("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 0, 1'b1, 1);
    chk("sw_wrap_nbeats", log_q.size(), 0);
`endif

    // illegal function codes
    issue("sbu_illegal", 1'b1, 3'b100, 32'h40, 32'h1, 0, 1'b1, 1);
    issue("ld32_illegal", 1'b0, 3'b011, 32'h8, 0, 0, 1'b1, 1);
    issue("lwu32_illegal", 1'b0, 3'b110, 32'h8, 0, 0, 1'b1, 1);
    issue("f3_7_illegal", 1'b0, 3'b111, 32'h8, 0, 0, 1'b1, 1);
    chk("illegal_nbeats", log_q.size(), 0);

    // reset in the middle of a waited access, then a stray mem_resp in IDLE
    wait_n = 3;
    @(negedge clk);
    b32.req_valid = 1'b1; b32.req_we = 1'b0; b32.req_funct3 = 3'b010; b32.req_addr = 32'h300;
    @(posedge clk);
    #1 b32.req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_read_before", b32.mem_read, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_read_dropped", b32.mem_read, 0);
    chk("midrst_ready_low", b32.req_ready, 0);
    chk("midrst_addr_zero", b32.mem_address, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_n = 0;
    @(posedge clk);
    #2 inject = 1'b1;
    @(posedge clk);
    #2 inject = 1'b0;
    @(negedge clk);
    chk("late_resp_ready", b32.req_ready, 1);
    chk("late_resp_no_read", b32.mem_read, 0);
    issue("lw_after_rst", 1'b0, 3'b010, 32'h100, 0, 32'hBBAA0000, 1'b0, 2);

    // 64-bit unit
    issue64("ld64", 3'b011, 32'h8, 64'h8877665544332211, 32'h8, 8'hFF, 64'h8877665544332211);
    issue64("lw64", 3'b010, 32'hC, 64'h80000000_00000000, 32'h8, 8'hF0, 64'hFFFFFFFF80000000);
    issue64("lwu64", 3'b110, 32'hC, 64'h80000000_00000000, 32'h8, 8'hF0, 64'h0000000080000000);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
